// File: rtl/dft_bin_engine.sv
// Direct-DFT bin sequencer and complex MAC: sweeps (k, n) into the twiddle ROM and sample RAM,
// accumulates x[n]*W over a 3-deep pipeline and presents each X[k] on a valid/ready port.
module dft_bin_engine #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [11:0]             n_points,
    output logic                    busy,
    output logic                    err,
    output logic [11:0]             rom_N,
    output logic [11:0]             rom_k,
    output logic [11:0]             rom_n,
    input  logic [31:0]             rom_data,
    output logic [11:0]             smp_addr,
    input  logic [31:0]             smp_data,
    output logic                    x_valid,
    input  logic                    x_ready,
    output logic signed [OUT_W-1:0] x_re,
    output logic signed [OUT_W-1:0] x_im,
    output logic [11:0]             x_k,
    output logic                    x_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]  state;
    logic        drain_cnt;
    logic        n_ok;
    logic [11:0] last_idx;

    // Stage tags: v0/f0 line up with ROM/RAM data, v1/f1 with the product registers.
    logic        v0, f0, v1, f1;
    logic signed [32:0]      p_re, p_im;
    logic signed [32:0]      pr_c, pi_c;
    logic signed [32:0]      ar, ai, cr, ci;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] pe_re, pe_im;

    assign n_ok     = (n_points >= 12'd2) && ((n_points & (n_points - 12'd1)) == 12'd0);
    assign last_idx = rom_N - 12'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            err       <= 1'b0;
            drain_cnt <= 1'b0;
            rom_N     <= 12'd0;
            rom_k     <= 12'd0;
            rom_n     <= 12'd0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_ok) begin
                            rom_N <= n_points;
                            rom_k <= 12'd0;
                            rom_n <= 12'd0;
                            state <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (rom_n == last_idx) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rom_n <= rom_n + 12'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state <= S_OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: begin
                    if (x_ready) begin
                        if (rom_k == last_idx) begin
                            state <= S_IDLE;
                        end else begin
                            rom_k <= rom_k + 12'd1;
                            rom_n <= 12'd0;
                            state <= S_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign ar = {{17{smp_data[31]}}, smp_data[31:16]};
    assign ai = {{17{smp_data[15]}}, smp_data[15:0]};
    assign cr = {{17{rom_data[31]}}, rom_data[31:16]};
    assign ci = {{17{rom_data[15]}}, rom_data[15:0]};

    assign pr_c = ar * cr - ai * ci;
    assign pi_c = ar * ci + ai * cr;

    assign pe_re = {{(ACC_W-33){p_re[32]}}, p_re};
    assign pe_im = {{(ACC_W-33){p_im[32]}}, p_im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0     <= 1'b0;
            f0     <= 1'b0;
            v1     <= 1'b0;
            f1     <= 1'b0;
            p_re   <= '0;
            p_im   <= '0;
            acc_re <= '0;
            acc_im <= '0;
        end else begin
            v0 <= (state == S_RUN);
            f0 <= (rom_n == 12'd0);
            v1 <= v0;
            f1 <= f0;
            if (v0) begin
                p_re <= pr_c;
                p_im <= pi_c;
            end
            // The first product of a bin overwrites the accumulator, so no clear cycle is needed.
            if (v1) begin
                acc_re <= f1 ? pe_re : acc_re + pe_re;
                acc_im <= f1 ? pe_im : acc_im + pe_im;
            end
        end
    end

    function automatic logic signed [OUT_W-1:0] sat_q15(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 15;
        if ((&s[ACC_W-1:OUT_W-1]) || (~|s[ACC_W-1:OUT_W-1])) begin
            return s[OUT_W-1:0];
        end else if (s[ACC_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    // Accumulators are frozen once drained, so the outputs stay stable throughout OUT.
    assign x_re     = sat_q15(acc_re);
    assign x_im     = sat_q15(acc_im);
    assign x_k      = rom_k;
    assign x_valid  = (state == S_OUT);
    assign x_last   = x_valid && (rom_k == last_idx);
    assign busy     = (state != S_IDLE);
    assign smp_addr = rom_n;

endmodule

// File: tb/tb_dft_bin_engine.sv
// Directed bench for dft_bin_engine with a behavioural twiddle ROM and sample RAM.
module tb_dft_bin_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, err, x_valid, x_ready, x_last;
    logic [11:0] n_points, rom_N, rom_k, rom_n, smp_addr, x_k;
    logic [31:0] rom_data, smp_data;
    logic signed [31:0] x_re, x_im;

    logic        s_start, s_busy, s_err, s_x_valid, s_x_last;
    logic [11:0] s_n_points, s_rom_N, s_rom_k, s_rom_n, s_smp_addr, s_x_k;
    logic [31:0] s_rom_data, s_smp_data;
    logic signed [15:0] s_x_re, s_x_im;

    logic [31:0] smp_mem   [0:15];
    logic [31:0] s_smp_mem [0:15];

    int checks = 0;
    int failures = 0;

    // Expected bins for x = [0.5, 0.5j, 0, 0], N=4
    int exp_re [4] = '{16383, 32767, 16383, 0};
    int exp_im [4] = '{16383, 0, -16384, 0};

    dft_bin_engine #(.ACC_W(48), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points), .busy(busy), .err(err),
        .rom_N(rom_N), .rom_k(rom_k), .rom_n(rom_n), .rom_data(rom_data),
        .smp_addr(smp_addr), .smp_data(smp_data), .x_valid(x_valid), .x_ready(x_ready),
        .x_re(x_re), .x_im(x_im), .x_k(x_k), .x_last(x_last)
    );

    dft_bin_engine #(.ACC_W(48), .OUT_W(16)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .n_points(s_n_points), .busy(s_busy), .err(s_err),
        .rom_N(s_rom_N), .rom_k(s_rom_k), .rom_n(s_rom_n), .rom_data(s_rom_data),
        .smp_addr(s_smp_addr), .smp_data(s_smp_data), .x_valid(s_x_valid), .x_ready(1'b1),
        .x_re(s_x_re), .x_im(s_x_im), .x_k(s_x_k), .x_last(s_x_last)
    );

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else return -$rtoi(-v + 0.5);
    endfunction

    function automatic logic [31:0] tw(input logic [11:0] nn, input logic [11:0] kk, input logic [11:0] ii);
        int  m, cv, sv;
        real ang;
        if (nn == 12'd0) return 32'd0;
        m   = ((4096 / int'(nn)) * int'(kk) * int'(ii)) % 4096;
        ang = 2.0 * 3.141592653589793 * real'(m) / 4096.0;
        cv  = rnd(32767.0 * $cos(ang));
        sv  = rnd(-32767.0 * $sin(ang));
        return {cv[15:0], sv[15:0]};
    endfunction

    always @(posedge clk) begin
        rom_data   <= tw(rom_N, rom_k, rom_n);
        smp_data   <= smp_mem[smp_addr[3:0]];
        s_rom_data <= tw(s_rom_N, s_rom_k, s_rom_n);
        s_smp_data <= s_smp_mem[s_smp_addr[3:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] n);
        start    = 1'b1;
        n_points = n;
        step();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) smp_mem[i] = 32'd0;
    endtask

    // Waits (bounded) for a presented bin, captures it, then lets the handshake edge pass.
    task automatic get_bin(output int re, output int im, output int k, output logic last, output logic ok);
        int i;
        ok = 1'b0; re = 0; im = 0; k = 0; last = 1'b0; i = 0;
        while (!ok && i < 200) begin
            if (x_valid) begin
                re = $signed(x_re); im = $signed(x_im); k = int'(x_k); last = x_last; ok = 1'b1;
            end
            step();
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n_points = 12'd0; x_ready = 1'b1;
        s_start = 1'b0; s_n_points = 12'd0;
        clear_mem();
        for (int i = 0; i < 16; i++) s_smp_mem[i] = 32'd0;
        #1;
        checks++;
        if ({busy, err, x_valid, x_last} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got %b want 0000", {busy, err, x_valid, x_last});
        end
        checks++;
        if ({x_re, x_im} !== 64'd0) begin
            failures++; $display("FAIL reset_x got re=%0d im=%0d want 0", x_re, x_im);
        end
        checks++;
        if ({x_k, rom_k, rom_n, smp_addr, rom_N} !== 60'd0) begin
            failures++; $display("FAIL reset_idx got k=%0d rk=%0d rn=%0d sa=%0d N=%0d want 0", x_k, rom_k, rom_n, smp_addr, rom_N);
        end
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_n2();
        int re, im, k, cnt;
        logic last, ok;
        clear_mem();
        smp_mem[0] = 32'h4000_0000;
        smp_mem[1] = 32'h4000_0000;
        do_start(12'd2);
        cnt = 0;
        while (!x_valid && cnt < 50) begin step(); cnt++; end
        checks++;
        if (cnt !== 4) begin failures++; $display("FAIL n2_latency got %0d want 4", cnt); end
        get_bin(re, im, k, last, ok);
        checks++;
        if (!ok || re !== 32767 || im !== 0) begin
            failures++; $display("FAIL n2_bin0 got re=%0d im=%0d ok=%0b want 32767 0", re, im, ok);
        end
        checks++;
        if (k !== 0 || last !== 1'b0) begin failures++; $display("FAIL n2_bin0_tag got k=%0d last=%0b want 0 0", k, last); end
        get_bin(re, im, k, last, ok);
        checks++;
        if (!ok || re !== 0 || im !== 0) begin
            failures++; $display("FAIL n2_bin1 got re=%0d im=%0d ok=%0b want 0 0", re, im, ok);
        end
        checks++;
        if (k !== 1 || last !== 1'b1) begin failures++; $display("FAIL n2_bin1_tag got k=%0d last=%0b want 1 1", k, last); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL n2_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_impulse_n8();
        int re, im, k, lasts;
        logic last, ok;
        clear_mem();
        smp_mem[0] = 32'h7FFF_0000;
        do_start(12'd8);
        lasts = 0;
        for (int b = 0; b < 8; b++) begin
            get_bin(re, im, k, last, ok);
            if (last) lasts++;
            checks++;
            if (!ok || re !== 32766 || im !== 0) begin
                failures++; $display("FAIL imp_bin%0d got re=%0d im=%0d ok=%0b want 32766 0", b, re, im, ok);
            end
            checks++;
            if (k !== b || last !== (b == 7)) begin
                failures++; $display("FAIL imp_tag%0d got k=%0d last=%0b want %0d %0b", b, k, last, b, b == 7);
            end
        end
        checks++;
        if (lasts !== 1) begin failures++; $display("FAIL imp_last_count got %0d want 1", lasts); end
    endtask

    task automatic test_reject(input logic [11:0] n);
        start = 1'b1; n_points = n;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL reject_n%0d got err=%0b busy=%0b want 1 0", n, err, busy);
        end
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reject_n%0d_after got err=%0b busy=%0b want 0 0", n, err, busy);
        end
    endtask

    task automatic load_pattern4();
        clear_mem();
        smp_mem[0] = 32'h4000_0000;
        smp_mem[1] = 32'h0000_4000;
    endtask

    task automatic test_start_during_run();
        int re, im, k;
        logic last, ok;
        load_pattern4();
        do_start(12'd4);
        step();
        start = 1'b1; n_points = 12'd8;
        step();
        start = 1'b0;
        checks++;
        if (rom_N !== 12'd4 || busy !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL busy_start got N=%0d busy=%0b err=%0b want 4 1 0", rom_N, busy, err);
        end
        for (int b = 0; b < 4; b++) begin
            get_bin(re, im, k, last, ok);
            checks++;
            if (!ok || re !== exp_re[b] || im !== exp_im[b] || k !== b) begin
                failures++; $display("FAIL busy_start_bin%0d got re=%0d im=%0d k=%0d want %0d %0d %0d", b, re, im, k, exp_re[b], exp_im[b], b);
            end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_end got %0b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int re, im, k, cnt;
        logic last, ok;
        load_pattern4();
        do_start(12'd4);
        get_bin(re, im, k, last, ok);
        checks++;
        if (!ok || re !== exp_re[0] || im !== exp_im[0]) begin
            failures++; $display("FAIL bp_bin0 got re=%0d im=%0d want %0d %0d", re, im, exp_re[0], exp_im[0]);
        end
        x_ready = 1'b0;
        cnt = 0;
        while (!x_valid && cnt < 50) begin step(); cnt++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (x_valid !== 1'b1 || $signed(x_re) !== exp_re[1] || $signed(x_im) !== exp_im[1]
                || x_k !== 12'd1 || rom_n !== 12'd3) begin
                failures++; $display("FAIL bp_stall%0d got v=%0b re=%0d im=%0d k=%0d n=%0d want 1 %0d %0d 1 3",
                                     c, x_valid, x_re, x_im, x_k, rom_n, exp_re[1], exp_im[1]);
            end
            step();
        end
        x_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            get_bin(re, im, k, last, ok);
            checks++;
            if (!ok || re !== exp_re[b] || im !== exp_im[b] || k !== b) begin
                failures++; $display("FAIL bp_bin%0d got re=%0d im=%0d k=%0d want %0d %0d %0d", b, re, im, k, exp_re[b], exp_im[b], b);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        for (int i = 0; i < 16; i++) smp_mem[i] = 32'h1234_5678;
        do_start(12'd16);
        cnt = 0;
        while (rom_n !== 12'd5 && cnt < 50) begin step(); cnt++; end
        checks++;
        if (rom_n !== 12'd5) begin failures++; $display("FAIL midrst_reach got n=%0d want 5", rom_n); end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, err, x_valid, x_last} !== 4'b0000 || {x_re, x_im} !== 64'd0) begin
            failures++; $display("FAIL midrst_out got flags=%b re=%0d im=%0d want 0", {busy, err, x_valid, x_last}, x_re, x_im);
        end
        checks++;
        if ({x_k, rom_k, rom_n, smp_addr, rom_N} !== 60'd0) begin
            failures++; $display("FAIL midrst_idx got rn=%0d N=%0d want 0", rom_n, rom_N);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        int cnt;
        for (int i = 0; i < 16; i++) s_smp_mem[i] = (i < 4) ? 32'h7FFF_0000 : 32'd0;
        s_start = 1'b1; s_n_points = 12'd4;
        step();
        s_start = 1'b0;
        cnt = 0;
        while (!s_x_valid && cnt < 50) begin step(); cnt++; end
        checks++;
        if (s_x_valid !== 1'b1 || $signed(s_x_re) !== 32767 || $signed(s_x_im) !== 0 || s_x_k !== 12'd0) begin
            failures++; $display("FAIL sat_bin0 got v=%0b re=%0d im=%0d k=%0d want 1 32767 0 0", s_x_valid, s_x_re, s_x_im, s_x_k);
        end
        cnt = 0;
        while (s_busy && cnt < 100) begin step(); cnt++; end
        checks++;
        if (s_busy !== 1'b0) begin failures++; $display("FAIL sat_done got busy=%0b want 0", s_busy); end
    endtask

    initial begin
        test_reset();
        test_n2();
        test_impulse_n8();
        test_reject(12'd3);
        test_reject(12'd0);
        test_start_during_run();
        test_backpressure();
        test_reset_mid_run();
        test_n2();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dft_bin_engine.md
# dft_bin_engine

Direct-DFT sequencing and multiply-accumulate engine that sits directly downstream of the twiddle ROM and drives its index ports. For each output bin k = 0..N-1 it sweeps n = 0..N-1 and presents (N, k, n) to the ROM and n to an external sample RAM. It multiplies each returned sample x[n] by the returned twiddle W, accumulates the complex products and streams X[k] out on a valid/ready interface. It is the reference (non-FFT) transform path that the FFT datapath is checked against.

## Interface
- ACC_W, 48: signed accumulator width per real/imag component.
- OUT_W, 32: signed output width per component.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin transform; sampled only in IDLE.
- n_points  in  12  transform length N; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when start is rejected.
- rom_N  out  12  latched N, driven to the ROM N port.
- rom_k  out  12  current bin, driven to the ROM k_index port.
- rom_n  out  12  current sample index, driven to the ROM n_index port.
- rom_data  in  32  twiddle, {re[31:16], im[15:0]}, Q1.15, one-cycle latency.
- smp_addr  out  12  sample RAM address (= rom_n).
- smp_data  in  32  sample, {re[31:16], im[15:0]}, Q1.15, one-cycle latency.
- x_valid  out  1  X[k] available.
- x_ready  in  1  consumer accepts.
- x_re, x_im  out  OUT_W each  bin result.
- x_k  out  12  bin index of the presented result.
- x_last  out  1  high with x_valid when x_k = N-1.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE, start=1, N a power of two in 2..2048: latch N, set k=0, n=0, go to RUN.
- IDLE, start=1, any other N (0, 1, non-power-of-two): err=1 for one cycle, stay in IDLE.
- start while busy is ignored.
- RUN: present n on rom_n/smp_addr each cycle, n increments by 1. After n=N-1 is presented, go to DRAIN.
- DRAIN: 2 cycles, flushing the pipeline; then go to OUT.
- The ROM wraps (4096/N)·k·n modulo 4096 itself. The engine drives raw k and n with no reduction.
- Pipeline stage 1: rom_data/smp_data arrive, registered with tag first = (n==0).
- Pipeline stage 2: products pr = ar·cr − ai·ci and pi = ar·ci + ai·cr, each 33-bit signed, registered with the tag. Here a is the sample and c is the twiddle.
- Pipeline stage 3: acc = first ? sign-extended product : acc + product, in ACC_W bits per component. There is no separate clear cycle.
- OUT: x_re/x_im = sat_OUT_W(acc >>> 15), arithmetic shift (floor), saturating to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- OUT: x_k = k; x_valid held high with all x_* stable until x_ready=1.
- OUT handshake (x_valid & x_ready): if k = N-1, go to IDLE; else k++, n=0, go to RUN.
- rom_N holds the latched N in all states. rom_k/rom_n hold their last values outside RUN.

## Timing
- Reset (async, immediate) values:
  - state = IDLE; busy, err, x_valid, x_last = 0.
  - x_re, x_im, x_k, rom_k, rom_n, smp_addr, rom_N = 0.
  - Accumulators and pipeline registers = 0.
- Reset asserted mid-RUN/DRAIN/OUT aborts the transform. No partial result is ever emitted.
- Start accepted at edge E0:
  - n=0 is presented in the cycle after E0.
  - n=N−1 is presented after E(N−1).
  - DRAIN occupies the cycles after E_N and E(N+1).
  - x_valid rises after E(N+2), i.e. N+2 cycles after the start edge.
- With x_ready held high, each bin costs N+3 cycles. The next bin's RUN begins the cycle after the handshake edge.
- busy falls on the edge that completes the x_last handshake. A new start is accepted the following cycle.
- x_ready low in OUT: the pipeline is already drained and indices are frozen, so there is no data loss.

## Test plan
- Behavioural ROM model: W[m] = round(32767·(cos, −sin)(2πm/4096)), with W[0]=0x7FFF_0000 and W[2048]=0x8001_0000. This model applies to every scenario below.
- N=2, x=[0x4000_0000, 0x4000_0000], x_ready=1:
  - X[0] re=32767, im=0, x_k=0, x_last=0; x_valid rises 4 cycles after the start edge.
  - X[1] re=0, im=0, x_last=1; busy=0 after its handshake.
- N=8 impulse, x[0]=0x7FFF_0000, rest 0 -> all eight bins re=32766, im=0, x_k 0..7, one x_last on k=7.
- Backpressure: N=4, x_ready low 5 cycles in OUT -> x_valid, x_re, x_im, x_k stable; rom_n unchanged; after release, results identical to the unstalled run.
- Rejection:
  - start with N=3 -> err pulse, busy stays 0.
  - start with N=0 -> err pulse, busy stays 0.
  - start during RUN -> ignored; the transform finishes unaffected.
- Reset mid-RUN at n=5, N=16 -> all outputs 0 immediately. Then start with N=2 -> correct results as in the N=2 scenario, with no stale accumulation.
- Saturation, OUT_W=16, N=4, all x=0x7FFF_0000 -> X[0] re=32767 (saturated from 131064), im=0.
